// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the external memory port used by mem_port_arbiter.
// Handshake: a requester holds req_valid and its fields until the cycle req_ready is high (transfer on that edge);
// mem_valid holds with stable fields until mem_ready; resp_valid and mem_resp_valid are one-cycle strobes, never stalled.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [1:0]            resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output mem_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between LSU (port 0) and fetch (port 1), one transaction outstanding at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise port 0 always wins conflicts.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  win;
    logic [1:0]            req_ready_c;
    logic [1:0]            resp_valid_c;
    logic                  mem_valid_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_q, last_d;

    // On a conflict the port not granted last time wins.
    always_comb begin
        if (&bus.req_valid) win = ~last_q;
        else                win = bus.req_valid[1];
    end
`else
    always_comb begin
        win = ~bus.req_valid[0];
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_ready_c  = 2'b00;
        resp_valid_c = 2'b00;
        mem_valid_c  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready_c[win] = 1'b1;
                    owner_d          = win;
                    mem_we_d         = bus.req_we[win];
                    mem_addr_d       = win ? bus.req_addr1 : bus.req_addr0;
                    mem_wdata_d      = win ? bus.req_wdata1 : bus.req_wdata0;
                    state_d          = ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d           = win;
`endif
                end
            end
            ISSUE: begin
                mem_valid_c = 1'b1;
                if (bus.mem_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_valid_c[owner_q] = 1'b1;
                    state_d               = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    // Strobes are forced low while reset is held, even though the FSM already sits in IDLE.
    assign bus.req_ready  = req_ready_c & {2{rst_n}};
    assign bus.resp_valid = resp_valid_c & {2{rst_n}};
    assign bus.resp_rdata = bus.mem_rdata;
    assign bus.mem_valid  = mem_valid_c;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level reference model plus expected queues.
// Honours MEM_ARB_ROUND_ROBIN_EN to select the expected conflict rule.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard state, written only by the monitor.
    int          total = 0;
    int          bad   = 0;
    logic [64:0] mem_exp_q[$];   // {we, addr, wdata}
    logic [33:0] resp_q[$];      // {port, we, rdata}
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] dev_mem[logic [AW-1:0]];
    logic [AW-1:0] dev_addr;
    bit          busy, issue_pend, wait_pend;
    bit          last_g = 1'b1;
    logic [1:0]  acc = 2'b00;
    bit          in_rst = 1'b0;

    // Driver-owned flags.
    bit          drv_done = 1'b0;
    bit          timeout_flag = 1'b0;
    bit          was_wait = 1'b0;
    int          dly = 0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    // Expected grant vector for the requests seen while the arbiter is free.
    function automatic logic [1:0] pick(input logic [1:0] v);
        if (v == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return last_g ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (state=%0d) at %0t", nm, act, exp, state_dbg, $time);
        end
    endtask

    task automatic clear_model();
        mem_exp_q.delete();
        resp_q.delete();
        busy       = 1'b0;
        issue_pend = 1'b0;
        wait_pend  = 1'b0;
        last_g     = 1'b1;
        acc        = 2'b00;
    endtask

    // Monitor: samples at the falling edge (and just after an asynchronous reset).
    initial begin : monitor
        bit          bb, bi, bw, w, we;
        logic [64:0] e;
        logic [33:0] r;
        logic [1:0]  exp_rv, exp_rdy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        while (!drv_done) begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                if (!in_rst) begin
                    #1;
                    chk("rst_mem_valid",  64'(bus.mem_valid),  64'(0));
                    chk("rst_mem_we",     64'(bus.mem_we),     64'(0));
                    chk("rst_mem_addr",   64'(bus.mem_addr),   64'(0));
                    chk("rst_mem_wdata",  64'(bus.mem_wdata),  64'(0));
                    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
                    chk("rst_req_ready",  64'(bus.req_ready),  64'(0));
                    clear_model();
                    in_rst = 1'b1;
                end else if (!clk) begin
                    chk("rst_hold_resp_valid", 64'(bus.resp_valid), 64'(0));
                    chk("rst_hold_req_ready",  64'(bus.req_ready),  64'(0));
                end
            end else begin
                in_rst = 1'b0;
                bb = busy; bi = issue_pend; bw = wait_pend;
                // Memory request side.
                chk("mem_valid", 64'(bus.mem_valid), 64'(bi));
                if (bi && mem_exp_q.size() > 0) begin
                    e = mem_exp_q[0];
                    chk("mem_we",    64'(bus.mem_we),    64'(e[64]));
                    chk("mem_addr",  64'(bus.mem_addr),  64'(e[63:32]));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
                    if (bus.mem_ready) begin
                        void'(mem_exp_q.pop_front());
                        issue_pend = 1'b0;
                        wait_pend  = 1'b1;
                        dev_addr   = bus.mem_addr;
                        if (bus.mem_we) dev_mem[bus.mem_addr] = bus.mem_wdata;
                    end
                end
                // Response side: only a response during WAIT reaches a requester.
                exp_rv = 2'b00;
                if (bw && bus.mem_resp_valid && resp_q.size() > 0)
                    exp_rv = resp_q[0][33] ? 2'b10 : 2'b01;
                chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
                if (bw && bus.mem_resp_valid && resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    if (!r[32]) chk("resp_rdata", 64'(bus.resp_rdata), 64'(r[31:0]));
                    wait_pend = 1'b0;
                    busy      = 1'b0;
                end
                // Request side.
                exp_rdy = bb ? 2'b00 : pick(bus.req_valid);
                chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
                acc = bus.req_ready & bus.req_valid;
                if (exp_rdy != 2'b00) begin
                    w  = exp_rdy[1];
                    we = bus.req_we[w];
                    a  = w ? bus.req_addr1  : bus.req_addr0;
                    d  = w ? bus.req_wdata1 : bus.req_wdata0;
                    mem_exp_q.push_back({we, a, d});
                    if (we) ref_mem[a] = d;
                    resp_q.push_back({w, we, (we ? '0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a)))});
                    last_g     = w;
                    busy       = 1'b1;
                    issue_pend = 1'b1;
                end
            end
        end
        chk("reset_phase_timeout", 64'(timeout_flag), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic new_req(input int p);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15)) << 2;
        bus.req_we[p] = 1'($urandom_range(0, 1));
        if (p == 0) begin
            bus.req_addr0  = a;
            bus.req_wdata0 = DW'($urandom);
        end else begin
            bus.req_addr1  = a;
            bus.req_wdata1 = DW'($urandom);
        end
        bus.req_valid[p] = 1'b1;
    endtask

    // One cycle of requester and memory behaviour, driven shortly after the rising edge.
    task automatic drive_cycle(input int p_req, input int p_drop, input int p_rdy,
                               input bit strays, input bit hold_resp);
        @(posedge clk);
        #2;
        for (int p = 0; p < 2; p++) begin
            if (bus.req_valid[p] && acc[p])
                bus.req_valid[p] = 1'b0;
            else if (bus.req_valid[p] && $urandom_range(0, 99) < p_drop)
                bus.req_valid[p] = 1'b0;
            if (!bus.req_valid[p] && $urandom_range(0, 99) < p_req)
                new_req(p);
        end
        if (wait_pend) begin
            if (!was_wait) dly = $urandom_range(0, 3);
            if (!hold_resp && dly == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = dev_mem.exists(dev_addr) ? dev_mem[dev_addr] : dflt(dev_addr);
            end else begin
                bus.mem_resp_valid = 1'b0;
                bus.mem_rdata      = DW'($urandom);
                if (dly > 0) dly--;
            end
        end else begin
            bus.mem_resp_valid = strays && ($urandom_range(0, 9) == 0);
            bus.mem_rdata      = DW'($urandom);
        end
        was_wait      = wait_pend;
        bus.mem_ready = ($urandom_range(0, 99) < p_rdy);
    endtask

    initial begin : driver
        rst_n              = 1'b0;
        bus.req_valid      = 2'b00;
        bus.req_we         = 2'b00;
        bus.req_addr0      = '0;
        bus.req_addr1      = '0;
        bus.req_wdata0     = '0;
        bus.req_wdata1     = '0;
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Both ports always requesting: every grant is a conflict.
        repeat (80)  drive_cycle(100, 0, 65, 1'b0, 1'b0);
        // Mixed traffic with stray responses and dropped requests.
        repeat (400) drive_cycle(35, 5, 65, 1'b1, 1'b0);
        // Heavy memory backpressure.
        repeat (200) drive_cycle(35, 5, 15, 1'b1, 1'b0);

        // Reach WAIT, then reset with a late response on the wire.
        for (int i = 0; i < 200 && !wait_pend; i++) drive_cycle(100, 0, 65, 1'b0, 1'b1);
        if (!wait_pend) timeout_flag = 1'b1;
        rst_n              = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hBAD0_BAD0;
        bus.req_valid      = 2'b00;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        new_req(1);
        repeat (200) drive_cycle(35, 5, 65, 1'b1, 1'b0);
        drv_done = 1'b1;
    end

endmodule
